// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read/write FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register bank: NUM_REGS words, one synchronous write port, one combinational read port.
module axil_reg_bank #(
  parameter int  NUM_REGS   = 16,
  parameter int  DATA_WIDTH = 32,
  localparam int IDXW       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDXW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDXW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Storage: cleared on reset, one word updated per committed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read is combinational so a same-edge write is not yet visible (pre-write value)
  assign rdata = regs[raddr];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite subordinate mapping NUM_REGS read/write registers.
// Optional feature: define AXIL_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int LSB  = $clog2(DATA_WIDTH / 8);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_fire;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A held beat takes priority over the bus, since its ready is low anyway
  assign wr_addr     = aw_held ? aw_addr_reg : awaddr;
  assign wr_data     = w_held ? w_data_reg : wdata;
  assign wr_fire     = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_in_range = wr_addr < ADDR_LIMIT;
  assign rd_in_range = araddr < ADDR_LIMIT;

  axil_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_fire && wr_in_range),
    .waddr (wr_addr[LSB +: IDXW]),
    .wdata (wr_data),
    .raddr (araddr[LSB +: IDXW]),
    .rdata (bank_rdata)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state    <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_fire) begin
            bvalid   <= 1'b1;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            wr_state <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held     <= 1'b1;
              aw_addr_reg <= awaddr;
            end
            if (w_hs) begin
              w_held     <= 1'b1;
              w_data_reg <= wdata;
            end
            // Also raises the readies on the first edge after reset
            awready <= !(aw_held || aw_hs);
            wready  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read FSM: capture the addressed word on AR, hold R until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata    <= rd_in_range ? bank_rdata : '0;
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            rd_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
      endcase
    end
  end

`ifdef AXIL_SLAVE_SLVERR_EN
  logic [1:0] bresp_reg;
  logic [1:0] rresp_reg;

  // Error responses: flag accesses beyond the register window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_reg <= RESP_OKAY;
      rresp_reg <= RESP_OKAY;
    end else begin
      if (wr_fire) begin
        bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        rresp_reg <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign bresp = bresp_reg;
  assign rresp = rresp_reg;
`else
  assign bresp = RESP_OKAY;
  assign rresp = RESP_OKAY;
`endif

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite subordinate that terminates the five AXI-Lite channels driven by `axi_lite_master` and maps them onto a bank of `NUM_REGS` word-wide read/write registers. It sits directly downstream of the master and is the default target for bring-up and for the master's directed tests. Write and read paths are independent FSMs. AW and W may arrive in either order or together.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, register/data width; must be 32 or 64.
- `NUM_REGS`, 16, number of registers; power of two, ≥2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `awaddr`  in  ADDR_WIDTH  write address.
- `awvalid`  in  1  write address valid.
- `awready`  out  1  write address ready.
- `wdata`  in  DATA_WIDTH  write data.
- `wvalid`  in  1  write data valid.
- `wready`  out  1  write data ready.
- `bresp`  out  2  write response.
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response ready.
- `araddr`  in  ADDR_WIDTH  read address.
- `arvalid`  in  1  read address valid.
- `arready`  out  1  read address ready.
- `rdata`  out  DATA_WIDTH  read data.
- `rresp`  out  2  read response.
- `rvalid`  out  1  read data valid.
- `rready`  in  1  read data ready.

## Operation
- **Handshake.** A beat transfers on a rising edge with `valid && ready`. All outputs are registered.
- **Address decode.**
  - Word index = `addr[LSB +: IDXW]`, where `LSB = $clog2(DATA_WIDTH/8)` and `IDXW = $clog2(NUM_REGS)`.
  - Low `LSB` bits are ignored, so unaligned addresses hit their containing word.
  - Address is in range iff `addr < NUM_REGS*(DATA_WIDTH/8)`.
- **Write FSM, states W_IDLE and W_RESP.**
  - W_IDLE:
    - `awready = !aw_held` and `wready = !w_held`.
    - A handshaked AW or W is captured into its holding register.
    - On the edge where both are available (held or handshaking that edge), the write commits if in range.
    - On that same edge: `bvalid <= 1`, `bresp` is set, both held flags clear, `awready`/`wready` drop to 0, and the FSM moves to W_RESP.
  - W_RESP:
    - `awready = wready = 0`.
    - On `bready`: `bvalid <= 0`, FSM returns to W_IDLE, and `awready`/`wready` go back to 1.
- **Read FSM, states R_IDLE and R_DATA.**
  - R_IDLE: `arready = 1`.
  - On AR handshake:
    - `rdata <= reg[idx]`, or 0 if out of range.
    - `rresp` is set, `rvalid <= 1`, `arready <= 0`, FSM moves to R_DATA.
  - R_DATA: holds `rdata`, `rresp` and `rvalid` stable until `rready`, then returns to R_IDLE with `arready <= 1`.
- **Out-of-range write.** Dropped; no register changes.
- **Same-edge write commit and AR handshake to one register.** `rdata` returns the pre-write value.
- **Backpressure.** `bvalid` and `rvalid` never drop without their ready. `bresp`/`rresp` are 2'b00 unless set to an error by the configuration feature.

## Timing
- **Reset values.**
  - All registers 0.
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - First edge after `rst_n` rises: `awready`, `wready`, `arready` go to 1.
- **Write latency.** `bvalid` is visible the cycle after the edge on which the second of AW/W handshakes. The register value is updated on that same edge.
- **Read latency.** `rvalid` and `rdata` are visible the cycle after the AR handshake edge.
- **Throughput.** One write per 2 cycles and one read per 2 cycles when ready/valid are held high. Reads and writes proceed concurrently.
- **Reset mid-transaction.** Asynchronous return to reset values. Held AW/W and pending responses are discarded.

## Configuration
- Macro `AXIL_SLAVE_SLVERR_EN`.
- **Defined:**
  - An out-of-range access returns `bresp`/`rresp` = 2'b10 (SLVERR).
  - Out-of-range reads return `rdata` = 0.
- **Undefined:**
  - All responses are 2'b00 (OKAY).
  - Out-of-range writes are silently dropped and out-of-range reads return 0.
  - Response logic is absent.

## Structure
- **Shared package `axi_lite_pkg`:**
  - Response constants `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10.
  - FSM enums `wr_state_t` {W_IDLE, W_RESP} and `rd_state_t` {R_IDLE, R_DATA}.
- **Sub-module `axil_reg_bank`:**
  - `NUM_REGS` x `DATA_WIDTH` array.
  - One write port and one asynchronous read port.
  - Asynchronous active-low reset to 0.
- Top level holds both FSMs, the AW/W holding registers and address decode.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-run with `bvalid`=1 pending → all outputs 0 immediately; one cycle after release, `awready`=`wready`=`arready`=1; a read of 0x0 returns 0.
- **Write then read.** AW 0x8, then W 0xDEADBEEF two cycles later, `bready`=1 → `bvalid` one cycle after the W handshake with `bresp`=00; read 0x8 → `rdata`=0xDEADBEEF, `rvalid` one cycle after AR.
- **Order and backpressure.**
  - W 0x1234 precedes AW 0x4 → W held with `wready`=0; write commits on the AW edge.
  - `bready` held 0 for 5 cycles → `bvalid` stays 1 and `awready` stays 0 throughout.
- **Collision.** Same-edge write commit of 0x55 and AR to 0xC, whose old value is 0x11 → `rdata`=0x11; the next read of 0xC returns 0x55.
- **Out of range.** Write 0x40 with `NUM_REGS`=16 → no register changes; `bresp`=10 with `AXIL_SLAVE_SLVERR_EN`, else 00. Read 0x40 → `rdata`=0, with `rresp` following the same rule.
- **Concurrency and master integration.** Back-to-back writes and reads driven by `axi_lite_master` → `done_write`/`done_read` pulse, and `data_out` matches the written data for all 16 registers, including unaligned 0x5 mapping to word 1.
